// File: rtl/encode_mul_arbiter.sv
// Round-robin arbiter sharing one registered signed multiplier among NUM_REQ requesters.
// Optional macro ENCODE_MUL_ARB_SAT_EN saturates res_data instead of wrapping.
module encode_mul_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned A_W       = 40,
  parameter int unsigned B_W       = 27,
  parameter int unsigned P_W       = 66,
  parameter int unsigned RES_SHIFT = 16,
  parameter int unsigned RES_W     = 48
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [RES_W-1:0]       res_data,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
  input  logic [P_W-1:0]         mul_dout,
  output logic                   busy
);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic               res_valid_q, res_valid_d;
  logic               stall_c;
  logic               transfer_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    grant_idx_c;
  logic [ID_W-1:0]    scan_idx_c;
  logic               found_c;
  logic signed [P_W-1:0] shifted_c;

  assign stall_c = res_valid_q & ~res_ready;

  // Grant the first valid requester after the last winner, unless the result is blocked.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    scan_idx_c  = '0;
    found_c     = 1'b0;
    if (reset && !stall_c) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx_c = ID_W'((32'(rr_ptr_q) + 32'd1 + k) % NUM_REQ);
        if (!found_c && req_valid[scan_idx_c]) begin
          found_c             = 1'b1;
          grant_c[scan_idx_c] = 1'b1;
          grant_idx_c         = scan_idx_c;
        end
      end
    end
  end

  assign transfer_c = |(grant_c & req_valid);
  assign req_ready  = grant_c;
  assign mul_ce     = reset & ~stall_c;
  assign busy       = res_valid_q | (|req_valid);

  // Operand mux: zero unless a transfer is happening this cycle.
  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        mul_din0 = mul_din0 | req_a[i*A_W +: A_W];
        mul_din1 = mul_din1 | req_b[i*B_W +: B_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    if (transfer_c) begin
      rr_ptr_d    = grant_idx_c;
      res_id_d    = grant_idx_c;
      res_valid_d = 1'b1;
    end else if (!stall_c) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;

  // The multiplier freezes while stalled, so the shifted product holds with res_valid.
  assign shifted_c = $signed(mul_dout) >>> RES_SHIFT;

`ifdef ENCODE_MUL_ARB_SAT_EN
  logic hi_ones_c;
  logic hi_zeros_c;

  assign hi_ones_c  = &shifted_c[P_W-1:RES_W-1];
  assign hi_zeros_c = ~(|shifted_c[P_W-1:RES_W-1]);

  always_comb begin
    res_data = shifted_c[RES_W-1:0];
    if (!hi_ones_c && !hi_zeros_c) begin
      res_data = shifted_c[P_W-1] ? {1'b1, {(RES_W-1){1'b0}}}
                                  : {1'b0, {(RES_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    res_data = RES_W'(shifted_c);
  end
`endif

endmodule

// File: tb/tb_encode_mul_arbiter.sv
// Directed self-checking bench for encode_mul_arbiter with a behavioural registered multiplier.
module tb_encode_mul_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned A_W       = 40;
  localparam int unsigned B_W       = 27;
  localparam int unsigned P_W       = 66;
  localparam int unsigned RES_SHIFT = 16;
  localparam int unsigned RES_W     = 48;

  logic                   clk;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [ID_W-1:0]        res_id;
  logic [RES_W-1:0]       res_data;
  logic                   mul_ce;
  logic [A_W-1:0]         mul_din0;
  logic [B_W-1:0]         mul_din1;
  logic [P_W-1:0]         mul_dout;
  logic                   busy;

  int tests;
  int failed;

  // Results for default operands a=(i+1)<<16, b=i+10.
  logic [RES_W-1:0] exp_def [NUM_REQ];

  encode_mul_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W),
    .P_W(P_W), .RES_SHIFT(RES_SHIFT), .RES_W(RES_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed multiplier: registered, ce-gated, no reset.
  logic signed [P_W-1:0] ext_a, ext_b;
  assign ext_a = P_W'($signed(mul_din0));
  assign ext_b = P_W'($signed(mul_din1));
  always @(posedge clk) if (mul_ce) mul_dout <= ext_a * ext_b;

  task automatic set_default_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*A_W +: A_W] = A_W'((i + 1) * 65536);
      req_b[i*B_W +: B_W] = B_W'(i + 10);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = '1; res_ready = 1'b1;
    set_default_ops();
    step(); step(); #1;
    tests++; if (req_ready !== 4'b0000) begin failed++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    tests++; if (res_valid !== 1'b0) begin failed++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    tests++; if (mul_ce !== 1'b0) begin failed++; $display("FAIL reset_mul_ce got %b want 0", mul_ce); end
    tests++; if (res_id !== 2'd0) begin failed++; $display("FAIL reset_res_id got %0d want 0", res_id); end
    step(); reset = 1'b1; #1;
    tests++; if (req_ready !== 4'b0001) begin failed++; $display("FAIL reset_first_grant got %b want 0001", req_ready); end
    step(); req_valid = '0; #1;
    tests++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== exp_def[0]) begin
      failed++; $display("FAIL reset_first_result got v=%b id=%0d d=%h want v=1 id=0 d=%h", res_valid, res_id, res_data, exp_def[0]);
    end
  endtask

  task automatic test_single();
    step();
    req_valid = 4'b0100;
    req_a[2*A_W +: A_W] = A_W'(458752);
    req_b[2*B_W +: B_W] = B_W'(-3);
    #1;
    tests++; if (req_ready !== 4'b0100) begin failed++; $display("FAIL single_grant got %b want 0100", req_ready); end
    tests++; if (mul_din0 !== A_W'(458752) || mul_din1 !== B_W'(-3)) begin
      failed++; $display("FAIL single_operands got %h/%h", mul_din0, mul_din1);
    end
    step(); req_valid = '0; #1;
    tests++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== RES_W'(-21)) begin
      failed++; $display("FAIL single_result got v=%b id=%0d d=%h want v=1 id=2 d=%h", res_valid, res_id, res_data, RES_W'(-21));
    end
    tests++; if (mul_din0 !== '0 || mul_ce !== 1'b1 || busy !== 1'b1) begin
      failed++; $display("FAIL single_idle_outputs got din0=%h ce=%b busy=%b", mul_din0, mul_ce, busy);
    end
    step(); #1;
    tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL single_drain got v=%b busy=%b want 0/0", res_valid, busy); end
  endtask

  task automatic test_round_robin();
    set_default_ops();
    step(); reset = 1'b0; #1; reset = 1'b1;
    req_valid = '1; res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      #1;
      tests++; if (req_ready !== 4'(1 << (k % 4))) begin
        failed++; $display("FAIL rr_grant_%0d got %b want %b", k, req_ready, 4'(1 << (k % 4)));
      end
      if (k > 0) begin
        tests++; if (res_valid !== 1'b1 || res_id !== 2'((k - 1) % 4) || res_data !== exp_def[(k-1)%4]) begin
          failed++; $display("FAIL rr_result_%0d got v=%b id=%0d d=%h want id=%0d d=%h",
                             k, res_valid, res_id, res_data, (k - 1) % 4, exp_def[(k-1)%4]);
        end
      end
    end
    step(); req_valid = '0; #1;
    tests++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== exp_def[3]) begin
      failed++; $display("FAIL rr_last got v=%b id=%0d d=%h", res_valid, res_id, res_data);
    end
    step();
  endtask

  task automatic test_backpressure();
    step(); req_valid = 4'b0010; res_ready = 1'b1; #1;
    tests++; if (req_ready !== 4'b0010) begin failed++; $display("FAIL bp_grant1 got %b want 0010", req_ready); end
    step(); req_valid = 4'b0100; res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      #1;
      tests++; if (mul_ce !== 1'b0 || req_ready !== 4'b0000) begin
        failed++; $display("FAIL bp_stall_%0d got ce=%b ready=%b want 0/0000", c, mul_ce, req_ready);
      end
      tests++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== exp_def[1]) begin
        failed++; $display("FAIL bp_hold_%0d got v=%b id=%0d d=%h want id=1 d=%h", c, res_valid, res_id, res_data, exp_def[1]);
      end
    end
    step(); res_ready = 1'b1; #1;
    tests++; if (req_ready !== 4'b0100 || mul_ce !== 1'b1 || res_data !== exp_def[1]) begin
      failed++; $display("FAIL bp_release got ready=%b ce=%b d=%h", req_ready, mul_ce, res_data);
    end
    step(); req_valid = '0; #1;
    tests++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== exp_def[2]) begin
      failed++; $display("FAIL bp_next got v=%b id=%0d d=%h want id=2 d=%h", res_valid, res_id, res_data, exp_def[2]);
    end
  endtask

  task automatic test_overflow();
    logic [RES_W-1:0] exp_pos, exp_neg;
`ifdef ENCODE_MUL_ARB_SAT_EN
    exp_pos = 48'h7FFF_FFFF_FFFF;
    exp_neg = 48'h8000_0000_0000;
`else
    exp_pos = 48'hFFFF_FF7F_FC00;
    exp_neg = 48'h0000_0080_0000;
`endif
    step();
    req_valid = 4'b0001;
    req_a[0 +: A_W] = {1'b0, {(A_W-1){1'b1}}};
    req_b[0 +: B_W] = {1'b0, {(B_W-1){1'b1}}};
    #1;
    tests++; if (req_ready !== 4'b0001) begin failed++; $display("FAIL ovf_grant got %b want 0001", req_ready); end
    step();
    req_a[0 +: A_W] = {1'b1, {(A_W-1){1'b0}}};
    #1;
    tests++; if (res_valid !== 1'b1 || res_data !== exp_pos) begin
      failed++; $display("FAIL ovf_pos got v=%b d=%h want %h", res_valid, res_data, exp_pos);
    end
    tests++; if (req_ready !== 4'b0001) begin failed++; $display("FAIL ovf_lone_grant got %b want 0001", req_ready); end
    step(); req_valid = '0; #1;
    tests++; if (res_valid !== 1'b1 || res_data !== exp_neg) begin
      failed++; $display("FAIL ovf_neg got v=%b d=%h want %h", res_valid, res_data, exp_neg);
    end
  endtask

  task automatic test_reset_mid();
    set_default_ops();
    step(); req_valid = 4'b1000; #1;
    tests++; if (req_ready !== 4'b1000) begin failed++; $display("FAIL rmid_grant got %b want 1000", req_ready); end
    step(); req_valid = '0; #1;
    tests++; if (res_valid !== 1'b1 || res_id !== 2'd3) begin failed++; $display("FAIL rmid_pre got v=%b id=%0d", res_valid, res_id); end
    reset = 1'b0; #1;
    tests++; if (res_valid !== 1'b0 || mul_ce !== 1'b0 || res_id !== 2'd0) begin
      failed++; $display("FAIL rmid_async got v=%b ce=%b id=%0d want 0/0/0", res_valid, mul_ce, res_id);
    end
    step(); reset = 1'b1; req_valid = '1; #1;
    tests++; if (req_ready !== 4'b0001 || res_valid !== 1'b0) begin
      failed++; $display("FAIL rmid_restart got ready=%b v=%b want 0001/0", req_ready, res_valid);
    end
    step(); req_valid = '0; #1;
    tests++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== exp_def[0]) begin
      failed++; $display("FAIL rmid_result got v=%b id=%0d d=%h want id=0 d=%h", res_valid, res_id, res_data, exp_def[0]);
    end
  endtask

  initial begin
    tests = 0; failed = 0;
    exp_def[0] = 48'd10; exp_def[1] = 48'd22; exp_def[2] = 48'd36; exp_def[3] = 48'd52;
    reset = 1'b0; req_valid = '0; res_ready = 1'b1; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/encode_mul_arbiter.md
Name: encode_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one signed multiplier (registered product, ce-gated, one-cycle latency, no reset) among NUM_REQ requesters in the encoder datapath.
- Accepts operand pairs over valid/ready and drives the multiplier's ce and operand inputs.
- Tracks which requester owns the in-flight product and returns the scaled product with its requester ID over a single valid/ready result port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, result ID width, equal to clog2(NUM_REQ)
- A_W, 40, signed operand A width (multiplier din0)
- B_W, 27, signed operand B width (multiplier din1)
- P_W, 66, multiplier product width (dout)
- RES_SHIFT, 16, arithmetic right shift applied to the product
- RES_W, 48, result width after shift and narrowing

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
- req_a  in  NUM_REQ*A_W  packed signed operand A, requester i at [i*A_W +: A_W]
- req_b  in  NUM_REQ*B_W  packed signed operand B
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_id  out  ID_W  index of the requester owning res_data
- res_data  out  RES_W  scaled signed product
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  A_W  multiplier operand A
- mul_din1  out  B_W  multiplier operand B
- mul_dout  in  P_W  multiplier registered product
- busy  out  1  res_valid OR any req_valid

Behaviour:
- Reset (reset=0, asynchronous): res_valid=0, res_id=0, rr_ptr=NUM_REQ-1 (so requester 0 has first priority), req_ready=0. mul_ce, mul_din0 and mul_din1 are combinational; they are 0 while reset is asserted. Any in-flight product is dropped; the multiplier's stale content is never presented because res_valid=0.
- stall = res_valid AND NOT res_ready. can_issue = NOT stall.
- Grant (combinational): if can_issue, scan requesters starting at rr_ptr+1 mod NUM_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
- Transfer: a transfer occurs when req_valid[i] AND req_ready[i]. Requesters hold valid and operands stable until the transfer. req_valid does not depend on req_ready.
- mul_din0/mul_din1: equal the granted requester's operands in a transfer cycle, otherwise 0.
- mul_ce = NOT stall. The product register freezes exactly while the result is blocked.
- On a transfer at edge T: rr_ptr<=i, res_id<=i, res_valid<=1. At T+1 res_data reflects mul_dout.
- Latency: one cycle from transfer to res_valid.
- Throughput: one result per cycle while res_ready=1.
- No transfer and (NOT res_valid OR res_ready): res_valid<=0. mul_ce stays 1, which loads a 0*0 product; this is harmless.
- Result consumed and a new transfer in the same cycle: res_valid stays 1, res_id updates. No bubble.
- Stall: req_ready all 0; res_valid, res_id and res_data hold.
- Arithmetic: s = mul_dout >>> RES_SHIFT (sign-preserving). Default narrowing is truncation to the low RES_W bits (wrap).
- Fairness: with all requesters valid and res_ready=1, grants rotate 0,1,2,3,0,...
- A lone requester is granted every cycle.

Optional Feature:
- Macro ENCODE_MUL_ARB_SAT_EN.
- Defined: res_data saturates s to the signed RES_W range, [-2^(RES_W-1), 2^(RES_W-1)-1].
- Undefined: res_data is the low RES_W bits of s (wrap).
- Latency and handshake are identical in both builds.

Test Plan:
- Reset: hold reset=0 with all req_valid=1 -> req_ready=0, res_valid=0, mul_ce=0. Release reset -> first grant goes to requester 0.
- Single request: req 2 sends a=458752, b=-3 -> one cycle later res_valid=1, res_id=2, res_data=-21.
- Round-robin: all four valid, res_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; res_id follows one cycle later with no bubbles.
- Backpressure: result valid for req 1 with res_ready=0 for 3 cycles -> mul_ce=0, req_ready=0, res_data/res_id stable. Raise res_ready -> same-cycle grant to req 2, no product lost.
- Overflow: a=2^39-1, b=2^26-1 -> without macro res_data=0xFFFF_FF7F_FC00; with ENCODE_MUL_ARB_SAT_EN res_data=0x7FFF_FFFF_FFFF. Also a=-2^39, b=2^26-1 with the macro -> 0x8000_0000_0000.
- Reset mid-operation: assert reset the cycle after a transfer -> res_valid=0 immediately (asynchronous). After release, no stale result appears and rr_ptr restarts so requester 0 is granted first.
